// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
//   state_t         : in-service tracking FSM states
//   REG_*           : MMIO byte offsets of the register file
//   SPURIOUS_ID_DEF : default claim ID reported for a take with nothing selected
package intr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    localparam logic [3:0] REG_ENABLE  = 4'h0;
    localparam logic [3:0] REG_PENDING = 4'h4;
    localparam logic [3:0] REG_MODE    = 4'h8;
    localparam logic [3:0] REG_CLAIM   = 4'hC;

    localparam int unsigned SPURIOUS_ID_DEF = 31;

endpackage

// File: rtl/intr_sync_edge.sv
// Per-source two-flop synchroniser plus history flop.
//   clk, RST_n : clock, async active-low reset
//   d          : raw asynchronous source
//   level      : synchronised level (s2)
//   rise_c     : combinational rising-edge indication (s2 & ~s3)
module intr_sync_edge (
    input  logic clk,
    input  logic RST_n,
    input  logic d,
    output logic level,
    output logic rise_c
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level  = s2;
    assign rise_c = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronises and latches NSRC sources, picks the
// lowest-index enabled pending source, raises intr to the core FSM and tracks
// the in-service interrupt through int_taken / mret_exec.
//   clk, RST_n          : clock, async active-low reset
//   src                 : raw interrupt sources
//   int_taken, mret_exec: core FSM strobes
//   intr                : registered interrupt request
//   mmio_*              : register port (ENABLE, PENDING, MODE, CLAIM)
//   claim_id            : ID of the in-service source
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int unsigned NSRC        = 8,
    parameter int unsigned IDW         = 5,
    parameter int unsigned SPURIOUS_ID = SPURIOUS_ID_DEF
) (
    input  logic            clk,
    input  logic            RST_n,
    input  logic [NSRC-1:0] src,
    input  logic            int_taken,
    input  logic            mret_exec,
    output logic            intr,
    input  logic [3:0]      mmio_addr,
    input  logic            mmio_we,
    input  logic            mmio_re,
    input  logic [31:0]     mmio_wdata,
    output logic [31:0]     mmio_rdata,
    output logic [IDW-1:0]  claim_id
);

    logic [NSRC-1:0] level, rise;
    logic [NSRC-1:0] enable_q, mode_q, pend_q;
    logic [NSRC-1:0] req_c, take_clr_c, w1c_c, clr_c, pend_n_c;
    logic [IDW-1:0]  sel_c, claim_n_c;
    logic            any_c, intr_n_c;
    logic [31:0]     rd_c;
    state_t          state_q, state_n_c;

    logic unused_wdata;
    assign unused_wdata = &{1'b0, mmio_wdata};

    // Per-source synchroniser / edge detector
    for (genvar g = 0; g < NSRC; g++) begin : g_sync
        intr_sync_edge u_sync (
            .clk    (clk),
            .RST_n  (RST_n),
            .d      (src[g]),
            .level  (level[g]),
            .rise_c (rise[g])
        );
    end

    // Lowest-index enabled pending source wins
    assign req_c = pend_q & enable_q;
    assign any_c = |req_c;

    always_comb begin
        sel_c = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req_c[i]) sel_c = IDW'(i);
        end
    end

    // Next-state / output logic
    always_comb begin
        state_n_c  = state_q;
        intr_n_c   = 1'b0;
        claim_n_c  = claim_id;
        take_clr_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (int_taken) begin
                    state_n_c = ST_SVC;
                    claim_n_c = IDW'(SPURIOUS_ID);
                end else if (any_c) begin
                    state_n_c = ST_REQ;
                    intr_n_c  = 1'b1;
                end
            end
            ST_REQ: begin
                if (int_taken) begin
                    state_n_c = ST_SVC;
                    if (any_c) begin
                        claim_n_c = sel_c;
                        if (mode_q[sel_c]) take_clr_c = NSRC'(1) << sel_c;
                    end else begin
                        claim_n_c = IDW'(SPURIOUS_ID);
                    end
                end else if (!any_c) begin
                    state_n_c = ST_IDLE;
                end else begin
                    intr_n_c = 1'b1;
                end
            end
            ST_SVC: begin
                if (mret_exec) begin
                    state_n_c = ST_IDLE;
                    claim_n_c = '0;
                end
            end
            default: state_n_c = ST_IDLE;
        endcase
    end

    // Pending update: edge bits set on rise (set beats clear), level bits follow s2
    assign w1c_c    = (mmio_we && mmio_addr == REG_PENDING) ? (mmio_wdata[NSRC-1:0] & mode_q) : '0;
    assign clr_c    = w1c_c | take_clr_c;
    assign pend_n_c = (mode_q & ((pend_q & ~clr_c) | rise)) | (~mode_q & level);

    // Register read mux
    always_comb begin
        rd_c = '0;
        case (mmio_addr)
            REG_ENABLE:  rd_c[NSRC-1:0] = enable_q;
            REG_PENDING: rd_c[NSRC-1:0] = pend_q;
            REG_MODE:    rd_c[NSRC-1:0] = mode_q;
            REG_CLAIM: begin
                rd_c[31]      = (state_q == ST_SVC);
                rd_c[IDW-1:0] = claim_id;
            end
            default: rd_c = '0;
        endcase
    end

    // State, configuration and output registers
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= ST_IDLE;
            intr       <= 1'b0;
            claim_id   <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            mmio_rdata <= '0;
        end else begin
            state_q  <= state_n_c;
            intr     <= intr_n_c;
            claim_id <= claim_n_c;
            pend_q   <= pend_n_c;
            if (mmio_we && mmio_addr == REG_ENABLE) enable_q <= mmio_wdata[NSRC-1:0];
            if (mmio_we && mmio_addr == REG_MODE)   mode_q   <= mmio_wdata[NSRC-1:0];
            if (mmio_re) mmio_rdata <= rd_c;
        end
    end

endmodule
